// File: rtl/bist_pkg.sv
// Shared definitions for the BIST pattern checker: LFSR polynomial, error
// type codes and controller state encoding.
package bist_pkg;

    localparam logic [7:0] LFSR_TAPS    = 8'hB8;
    localparam logic [1:0] ERR_MISMATCH = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    // Fibonacci step, shift left; feedback is the XOR of bits 7,5,4,3.
    function automatic logic [7:0] lfsr8_next(input logic [7:0] v);
        return {v[6:0], ^(v & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/bist_lfsr8.sv
// 8-bit Fibonacci LFSR with synchronous load (priority) and advance strobes.
module bist_lfsr8
    import bist_pkg::*;
#(
    parameter logic [7:0] RESET_VAL = 8'hA5
) (
    input  logic       clk,
    input  logic       res_n,
    input  logic       load,
    input  logic [7:0] seed,
    input  logic       adv,
    output logic [7:0] q
);

    logic [7:0] q_q;
    logic [7:0] q_d;

    always_comb begin
        q_d = q_q;
        if (load) begin
            q_d = seed;
        end else if (adv) begin
            q_d = lfsr8_next(q_q);
        end
    end

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            q_q <= RESET_VAL;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/bist_pattern_checker.sv
// BIST engine: sends one pseudo-random byte at a time, checks the looped-back
// response against a second LFSR and reports the first failure.
module bist_pattern_checker
    import bist_pkg::*;
#(
    parameter int         N_PATTERNS = 64,
    parameter logic [7:0] SEED       = 8'hA5,
    parameter int         TIMEOUT    = 16
) (
    input  logic       clk,
    input  logic       res_n,
    input  logic       start,
    output logic [7:0] stim_data,
    output logic       stim_valid,
    input  logic [7:0] resp_data,
    input  logic       resp_valid,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic       Err_flag,
    output logic [7:0] Err_code
);

    localparam logic [7:0] LAST_IDX   = 8'(N_PATTERNS - 1);
    localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT - 1);

    state_t     state_q;
    logic [7:0] idx_q;
    logic [7:0] timer_q;
    logic [7:0] stim_data_q;
    logic       stim_valid_q;
    logic       busy_q;
    logic       done_q;
    logic       pass_q;
    logic       err_flag_q;
    logic [7:0] err_code_q;

    logic [7:0] gen_q;
    logic [7:0] exp_q;
    logic       run_load;
    logic       gen_adv;
    logic       exp_adv;
    logic       resp_match;

    // LFSR strobes must act on the same edge as the FSM transition.
    assign run_load   = start && ((state_q == IDLE) || (state_q == DONE));
    assign gen_adv    = (state_q == SEND);
    assign resp_match = (resp_data == exp_q);
    assign exp_adv    = (state_q == WAIT) && resp_valid && resp_match && (idx_q != LAST_IDX);

    bist_lfsr8 #(.RESET_VAL(SEED)) u_gen (
        .clk  (clk),
        .res_n(res_n),
        .load (run_load),
        .seed (SEED),
        .adv  (gen_adv),
        .q    (gen_q)
    );

    bist_lfsr8 #(.RESET_VAL(SEED)) u_exp (
        .clk  (clk),
        .res_n(res_n),
        .load (run_load),
        .seed (SEED),
        .adv  (exp_adv),
        .q    (exp_q)
    );

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            timer_q      <= '0;
            stim_data_q  <= '0;
            stim_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            err_flag_q   <= 1'b0;
            err_code_q   <= '0;
        end else begin
            stim_valid_q <= 1'b0;
            err_flag_q   <= 1'b0;
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        state_q      <= SEND;
                        idx_q        <= '0;
                        pass_q       <= 1'b0;
                        done_q       <= 1'b0;
                        busy_q       <= 1'b1;
                        stim_valid_q <= 1'b1;
                        stim_data_q  <= SEED;
                    end
                end
                SEND: begin
                    state_q <= WAIT;
                    timer_q <= '0;
                end
                WAIT: begin
                    // A response on the timeout cycle takes priority.
                    if (resp_valid) begin
                        if (!resp_match) begin
                            state_q    <= DONE;
                            busy_q     <= 1'b0;
                            done_q     <= 1'b1;
                            pass_q     <= 1'b0;
                            err_flag_q <= 1'b1;
                            err_code_q <= {ERR_MISMATCH, idx_q[5:0]};
                        end else if (idx_q == LAST_IDX) begin
                            state_q <= DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            pass_q  <= 1'b1;
                        end else begin
                            state_q      <= SEND;
                            idx_q        <= idx_q + 8'd1;
                            stim_valid_q <= 1'b1;
                            stim_data_q  <= gen_q;
                        end
                    end else if (timer_q == TIMER_LAST) begin
                        state_q    <= DONE;
                        busy_q     <= 1'b0;
                        done_q     <= 1'b1;
                        pass_q     <= 1'b0;
                        err_flag_q <= 1'b1;
                        err_code_q <= {ERR_TIMEOUT, idx_q[5:0]};
                    end else begin
                        timer_q <= timer_q + 8'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign stim_data  = stim_data_q;
    assign stim_valid = stim_valid_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign pass       = pass_q;
    assign Err_flag   = err_flag_q;
    assign Err_code   = err_code_q;

endmodule

// File: tb/tb_bist_pattern_checker.sv
// Directed bench for bist_pattern_checker: loopback responder, stimulus
// scoreboard and checks on error pulses, codes and restart behaviour.
module tb_bist_pattern_checker;

    localparam int         N    = 64;
    localparam logic [7:0] SEED = 8'hA5;
    localparam int         TO   = 16;

    logic       clk = 1'b0;
    logic       res_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] resp_data = 8'h00;
    logic       resp_valid = 1'b0;
    logic [7:0] stim_data;
    logic       stim_valid;
    logic       busy;
    logic       done;
    logic       pass;
    logic       Err_flag;
    logic [7:0] Err_code;

    int checks = 0;
    int errors = 0;
    int stim_pulses = 0;
    int err_pulses = 0;
    logic [7:0] code_exp = 8'h00;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    bist_pattern_checker #(
        .N_PATTERNS(N),
        .SEED      (SEED),
        .TIMEOUT   (TO)
    ) dut (
        .clk       (clk),
        .res_n     (res_n),
        .start     (start),
        .stim_data (stim_data),
        .stim_valid(stim_valid),
        .resp_data (resp_data),
        .resp_valid(resp_valid),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .Err_flag  (Err_flag),
        .Err_code  (Err_code)
    );

    function automatic logic [7:0] model_next(input logic [7:0] v);
        return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Outputs are sampled and inputs driven on the falling edge.
    task automatic tick();
        @(negedge clk);
        if (stim_valid) stim_pulses++;
        if (Err_flag) err_pulses++;
    endtask

    task automatic run(input int corrupt_at, input int hold_at, input int abort_at, input int poke_at);
        logic [7:0] v;
        logic [7:0] got;
        int t;
        bit found;
        exp_q.delete();
        v = SEED;
        for (int i = 0; i < N; i++) begin
            exp_q.push_back(v);
            v = model_next(v);
        end
        stim_pulses = 0;
        err_pulses = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("stim_latency", stim_valid, 1);
        check("start_clears", {done, pass}, 0);
        check("code_hold_start", Err_code, code_exp);
        for (int i = 0; i < N; i++) begin
            found = 1'b0;
            for (int k = 0; k < 20; k++) begin
                if (stim_valid) begin
                    found = 1'b1;
                    break;
                end
                tick();
            end
            check("stim_seen", found, 1);
            if (!found) return;
            got = exp_q.pop_front();
            check($sformatf("stim_data[%0d]", i), stim_data, got);
            if (i == abort_at) begin
                res_n = 1'b0;
                #1;
                check("abort_outputs", {stim_valid, busy, done, pass, Err_flag, stim_data, Err_code}, 0);
                code_exp = 8'h00;
                tick();
                res_n = 1'b1;
                tick();
                check("abort_no_err", err_pulses, 0);
                check("abort_idle", {busy, done, stim_valid}, 0);
                return;
            end
            if (i == hold_at) begin
                t = 0;
                while (!Err_flag && t < 40) begin
                    tick();
                    t++;
                end
                code_exp = {2'b10, 6'(hold_at)};
                // SEND cycle + TO cycles in WAIT before the pulse.
                check("timeout_latency", t, TO + 1);
                check("timeout_code", Err_code, code_exp);
                check("timeout_pass_done", {pass, done, busy}, 3'b010);
                tick();
                check("timeout_pulse_once", Err_flag, 0);
                return;
            end
            if (i == poke_at) begin
                resp_valid = 1'b1;
                resp_data = ~got;
            end
            tick();
            resp_valid = 1'b0;
            if (i == poke_at) start = 1'b1;
            tick();
            start = 1'b0;
            resp_valid = 1'b1;
            resp_data = (i == corrupt_at) ? (got ^ 8'h10) : got;
            tick();
            resp_valid = 1'b0;
            if (i == corrupt_at) begin
                code_exp = {2'b01, 6'(i)};
                check("mm_flag", Err_flag, 1);
                check("mm_code", Err_code, code_exp);
                check("mm_pass_done", {pass, done, busy}, 3'b010);
                for (int k = 0; k < 8; k++) tick();
                check("mm_single_pulse", err_pulses, 1);
                check("mm_no_more_stim", stim_pulses, i + 1);
                check("mm_code_hold", Err_code, code_exp);
                return;
            end
        end
        check("pass_state", {done, pass, busy}, 3'b110);
        check("pass_stim_count", stim_pulses, N);
        check("pass_no_err", err_pulses, 0);
        check("pass_code_hold", Err_code, code_exp);
        check("scoreboard_empty", exp_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "simulation did not finish");
    end

    initial begin
        res_n = 1'b0;
        tick();
        tick();
        check("reset_outputs", {stim_valid, busy, done, pass, Err_flag, stim_data, Err_code}, 0);
        res_n = 1'b1;
        tick();
        tick();
        check("idle_quiet", {stim_valid, busy, done, Err_flag}, 0);

        // Plain loopback run.
        run(-1, -1, -1, -1);

        // Stray responses while DONE must not disturb the result.
        resp_valid = 1'b1;
        resp_data = 8'h00;
        tick();
        tick();
        resp_valid = 1'b0;
        tick();
        check("done_stray_resp", {done, pass, busy}, 3'b110);
        check("done_stray_no_err", err_pulses, 0);
        check("done_stray_no_stim", stim_pulses, N);

        // Mismatch at index 5.
        run(5, -1, -1, -1);
        check("mm_code_value", Err_code, 8'h45);

        // Restart from DONE with start-while-busy and stray resp in SEND.
        run(-1, -1, -1, 7);

        // Timeout at index 3.
        run(-1, 3, -1, -1);
        check("timeout_code_value", Err_code, 8'h83);

        // Reset mid-run, then a fresh run replays from SEED.
        run(-1, -1, 10, -1);
        run(-1, -1, -1, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bist_pattern_checker.md
Name: bist_pattern_checker

Overview:
- BIST engine that sits directly upstream of the BIST output buffer.
- Generates an 8-bit pseudo-random stimulus stream and receives the looped-back responses from the unit under test.
- Compares each response against an independently regenerated expected sequence.
- Reports the first failure as a one-cycle Err_flag with an 8-bit Err_code, the same pair the output buffer latches into its 16-bit status word.

Parameters:
- N_PATTERNS, 64, number of stimulus/response pairs per run (legal range 1..256).
- SEED, 8'hA5, LFSR start value for both generators (must be nonzero; 0 is illegal).
- TIMEOUT, 16, maximum cycles WAIT may last without resp_valid before a timeout error (legal range 1..255).

Ports:
- clk  input  1  system clock, rising edge.
- res_n  input  1  asynchronous active-low reset.
- start  input  1  single-cycle run request; honoured only in IDLE or DONE.
- stim_data  output  8  stimulus byte to the unit under test.
- stim_valid  output  1  stim_data is valid this cycle (one-cycle pulse).
- resp_data  input  8  response byte from the unit under test.
- resp_valid  input  1  resp_data is valid this cycle.
- busy  output  1  high in SEND and WAIT.
- done  output  1  high in DONE.
- pass  output  1  valid while done: 1 = all patterns matched.
- Err_flag  output  1  one-cycle error pulse to the output buffer.
- Err_code  output  8  error code: [7:6] type (2'b01 mismatch, 2'b10 timeout), [5:0] pattern index low bits.

Behaviour:
- Clock domain and reset: clk is the single clock. res_n is asynchronous and active-low; reset is applied immediately and released synchronously.
- Reset values: state = IDLE, all outputs 0, both LFSRs = SEED, idx = 0, timer = 0. Reset mid-run aborts with no Err_flag.
- LFSR: 8-bit Fibonacci, shift left, new bit[0] = b7^b5^b4^b3. From A5 the sequence is A5 -> 4A -> 95.
- gen LFSR drives stim_data. exp LFSR supplies the expected value.
- All outputs are registered.
- IDLE:
  - On start: load both LFSRs with SEED, idx = 0, clear pass, go to SEND.
- SEND:
  - stim_valid = 1 for exactly one cycle, with stim_data = gen.
  - gen advances at the end of that cycle.
  - timer = 0, go to WAIT.
- WAIT, resp_valid = 1:
  - Compare resp_data against exp.
  - Mismatch: Err_flag = 1 on the next cycle, Err_code = {2'b01, idx[5:0]}, pass = 0, go to DONE. Stop on first failure.
  - Match and idx == N_PATTERNS-1: pass = 1, go to DONE, no Err_flag.
  - Match otherwise: advance exp, idx++, go to SEND.
- WAIT, resp_valid = 0:
  - timer++.
  - When timer reaches TIMEOUT-1 and resp_valid is still 0: Err_flag, Err_code = {2'b10, idx[5:0]}, pass = 0, go to DONE.
  - If resp_valid arrives on the same cycle the timeout would fire, resp_valid wins.
- DONE:
  - done stays high.
  - start restarts the run as from IDLE, clearing done and pass the same cycle the state leaves DONE.
- Ignored inputs:
  - resp_valid outside WAIT, and extra responses, are ignored.
  - start while busy is ignored.
- Output rules:
  - Err_flag is high for exactly one cycle per run, or never.
  - Err_code holds its last value until the next error or reset.
  - idx width is 8 bits; N_PATTERNS = 256 ends at idx = 255 with no wrap.
- Latency:
  - stim_valid appears 1 cycle after start.
  - Err_flag appears 1 cycle after the failing resp_valid.

Decomposition:
- Package bist_pkg holds:
  - LFSR tap mask 8'hB8 and an lfsr8_next function.
  - Error type constants ERR_MISMATCH = 2'b01 and ERR_TIMEOUT = 2'b10.
  - State encoding IDLE/SEND/WAIT/DONE.
- Sub-module bist_lfsr8 (clk, res_n, load, seed, adv, q), instantiated twice (gen, exp).

Test Plan:
1. Loopback: resp_data = stim_data, resp_valid 2 cycles after stim_valid, N_PATTERNS = 64 -> stim sequence A5, 4A, 95, ...; 64 stim pulses; done = 1, pass = 1, Err_flag never asserts.
2. Inject mismatch: corrupt the response at idx 5 -> Err_flag is a single pulse, Err_code = 8'h45, pass = 0, done = 1, no further stim_valid.
3. Timeout: withhold resp_valid at idx 3 with TIMEOUT = 16 -> Err_flag 16 cycles after WAIT entry, Err_code = 8'h83, pass = 0.
4. Reset mid-run at idx 10 -> all outputs 0 immediately; a following start replays stim from A5.
5. start during busy and stray resp_valid in SEND/DONE -> no effect on idx, outputs or sequence.
6. Restart from DONE after a failure -> done/pass cleared, full pass run completes; Err_code retains 8'h45 from the previous run until overwritten.
